// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encodings and defaults for the data-memory responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_BUSY = 2'b01,
        DM_DONE = 2'b10
    } dm_state_e;

    localparam int DM_LAT = 3;

    // Word accesses only: any nonzero low byte-offset bit is a misalignment
    function automatic logic addr_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and asynchronous read
module dmem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Contents are deliberately left unreset
    logic [31:0] mem [2**ADDR_W];

    // Commit a store on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder that stalls the pipeline while busy
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = DM_LAT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic        mem_err
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    dm_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              req;
    logic              bad;
    logic              arr_we;
    logic [31:0]       arr_rdata;

    // Byte address bits above the array and the offset bits are not used for indexing
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    // Next-state, latch capture, array write enable and stall
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        arr_we    = 1'b0;
        mem_stall = 1'b0;
        req       = MemRead | MemWrite;
        bad       = addr_misaligned(addr) | (MemRead & MemWrite);

        case (state_q)
            DM_IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    if (bad) begin
                        // Rejected without touching memory or rdata
                        state_d = DM_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        op_wr_d = MemWrite;
                        idx_d   = addr[ADDR_W+1:2];
                        wdata_d = wdata;
                        cnt_d   = CNT_INIT;
                        state_d = DM_BUSY;
                    end
                end
            end
            DM_BUSY: begin
                mem_stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    if (op_wr_q) begin
                        arr_we = 1'b1;
                    end else begin
                        rdata_d = arr_rdata;
                    end
                    state_d = DM_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DM_DONE: begin
                // The stale request still on the bus is ignored here
                state_d = DM_IDLE;
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase

        // A reset landing on the commit cycle must drop the pending store
        if (reset) begin
            arr_we = 1'b0;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DM_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Request latches; only meaningful while BUSY so they carry no reset
    always_ff @(posedge clock) begin
        op_wr_q <= op_wr_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    dmem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clock),
        .we    (arr_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign rdata    = rdata_q;
    assign mem_done = done_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed checks of the data-memory responder at LAT=3 and LAT=1
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_in    [2];
    logic        wr_in    [2];
    logic [31:0] addr_in  [2];
    logic [31:0] wdata_in [2];
    logic [31:0] rdata_o  [2];
    logic        stall_o  [2];
    logic        done_o   [2];
    logic        err_o    [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(10), .LAT(3)) u_dut0 (
        .clock     (clk),
        .reset     (rst),
        .MemRead   (rd_in[0]),
        .MemWrite  (wr_in[0]),
        .addr      (addr_in[0]),
        .wdata     (wdata_in[0]),
        .rdata     (rdata_o[0]),
        .mem_stall (stall_o[0]),
        .mem_done  (done_o[0]),
        .mem_err   (err_o[0])
    );

    dmem_responder #(.ADDR_W(10), .LAT(1)) u_dut1 (
        .clock     (clk),
        .reset     (rst),
        .MemRead   (rd_in[1]),
        .MemWrite  (wr_in[1]),
        .addr      (addr_in[1]),
        .wdata     (wdata_in[1]),
        .rdata     (rdata_o[1]),
        .mem_stall (stall_o[1]),
        .mem_done  (done_o[1]),
        .mem_err   (err_o[1])
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one request at cycle 0, hold it through DONE, then drop it.
    task automatic access(input int sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_done, input logic exp_err,
                          input logic chk, input logic [31:0] exp_rd,
                          input string name, input bit churn,
                          output int done_cyc);
        int          stalls        = 0;
        int          done_at       = -1;
        logic        err_seen      = 1'b0;
        logic        stall_in_done = 1'b0;
        logic [31:0] rd_seen       = 32'd0;
        done_cyc      = -1;
        rd_in[sel]    = r;
        wr_in[sel]    = w;
        addr_in[sel]  = a;
        wdata_in[sel] = d;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (done_o[sel]) begin
                done_at       = c;
                err_seen      = err_o[sel];
                rd_seen       = rdata_o[sel];
                stall_in_done = stall_o[sel];
                done_cyc      = cyc;
                break;
            end
            if (stall_o[sel]) stalls++;
            @(posedge clk); #1;
            if (churn && c == 0) begin
                addr_in[sel]  = 32'h44;
                wdata_in[sel] = 32'd0;
            end
        end
        tests++;
        if (done_at !== exp_done) begin
            fails++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, exp_done);
        end
        tests++;
        if (stalls !== exp_done) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_done);
        end
        tests++;
        if (err_seen !== exp_err) begin
            fails++;
            $display("FAIL %s mem_err: got %0b want %0b", name, err_seen, exp_err);
        end
        tests++;
        if (stall_in_done !== 1'b0) begin
            fails++;
            $display("FAIL %s stall_in_done: got %0b want 0", name, stall_in_done);
        end
        if (chk) begin
            tests++;
            if (rd_seen !== exp_rd) begin
                fails++;
                $display("FAIL %s rdata: got %h want %h", name, rd_seen, exp_rd);
            end
        end
        @(posedge clk); #1;
        rd_in[sel] = 1'b0;
        wr_in[sel] = 1'b0;
        #1;
        tests++;
        if (done_o[sel] !== 1'b0 || stall_o[sel] !== 1'b0) begin
            fails++;
            $display("FAIL %s after_done: got done=%0b stall=%0b want 0/0", name, done_o[sel], stall_o[sel]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rd_in[s] = 1'b0; wr_in[s] = 1'b0; addr_in[s] = 32'd0; wdata_in[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            tests++;
            if (rdata_o[s] !== 32'd0 || done_o[s] !== 1'b0 || err_o[s] !== 1'b0 || stall_o[s] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state dut%0d: got rdata=%h done=%0b err=%0b stall=%0b want 0/0/0/0",
                         s, rdata_o[s], done_o[s], err_o[s], stall_o[s]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int dc;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4, 1'b0, 1'b1, 32'd0, "sw_0x10", 1'b0, dc);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 4, 1'b0, 1'b1, 32'hDEADBEEF, "lw_0x10", 1'b0, dc);
        access(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4, 1'b0, 1'b1, 32'hDEADBEEF, "sw_0x20", 1'b0, dc);
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, 4, 1'b0, 1'b1, 32'h0BADF00D, "lw_0x20", 1'b0, dc);
    endtask

    task automatic test_misaligned();
        int dc;
        access(0, 1'b1, 1'b0, 32'h13, 32'd0, 1, 1'b1, 1'b1, 32'h0BADF00D, "lw_misaligned", 1'b0, dc);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 4, 1'b0, 1'b1, 32'hDEADBEEF, "lw_0x10_after_err", 1'b0, dc);
    endtask

    task automatic test_conflict();
        int dc;
        access(0, 1'b1, 1'b1, 32'h20, 32'h1, 1, 1'b1, 1'b1, 32'hDEADBEEF, "conflict", 1'b0, dc);
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, 4, 1'b0, 1'b1, 32'h0BADF00D, "lw_0x20_after_conflict", 1'b0, dc);
    endtask

    task automatic test_input_churn();
        int dc;
        access(0, 1'b0, 1'b1, 32'h44, 32'h11111111, 4, 1'b0, 1'b0, 32'd0, "sw_0x44", 1'b0, dc);
        access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 4, 1'b0, 1'b1, 32'h0BADF00D, "sw_0x40_churn", 1'b1, dc);
        access(0, 1'b1, 1'b0, 32'h40, 32'd0, 4, 1'b0, 1'b1, 32'h12345678, "lw_0x40", 1'b0, dc);
        access(0, 1'b1, 1'b0, 32'h44, 32'd0, 4, 1'b0, 1'b1, 32'h11111111, "lw_0x44", 1'b0, dc);
    endtask

    task automatic test_reset_mid_access();
        int dc;
        access(0, 1'b0, 1'b1, 32'h50, 32'd0, 4, 1'b0, 1'b0, 32'd0, "sw_0x50_zero", 1'b0, dc);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 4, 1'b0, 1'b1, 32'hDEADBEEF, "lw_0x10_pre_reset", 1'b0, dc);
        rd_in[0] = 1'b0; wr_in[0] = 1'b1; addr_in[0] = 32'h50; wdata_in[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        #1;
        tests++;
        if (stall_o[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid busy_stall: got %0b want 1", stall_o[0]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        wr_in[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests++;
        if (stall_o[0] !== 1'b0 || done_o[0] !== 1'b0 || rdata_o[0] !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid idle: got stall=%0b done=%0b rdata=%h want 0/0/00000000",
                     stall_o[0], done_o[0], rdata_o[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (done_o[0] !== 1'b0 || stall_o[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid stays_idle: got done=%0b stall=%0b want 0/0", done_o[0], stall_o[0]);
        end
        access(0, 1'b1, 1'b0, 32'h50, 32'd0, 4, 1'b0, 1'b1, 32'd0, "lw_0x50_after_reset", 1'b0, dc);
    endtask

    task automatic test_lat1_wrap_back_to_back();
        int d0, d1;
        access(1, 1'b0, 1'b1, 32'h1000_0010, 32'hCAFEF00D, 2, 1'b0, 1'b0, 32'd0, "lat1_sw_wrap", 1'b0, d0);
        access(1, 1'b0, 1'b1, 32'h14, 32'h600DCAFE, 2, 1'b0, 1'b0, 32'd0, "lat1_sw_0x14", 1'b0, d0);
        access(1, 1'b1, 1'b0, 32'h10, 32'd0, 2, 1'b0, 1'b1, 32'hCAFEF00D, "lat1_lw_0x10", 1'b0, d0);
        access(1, 1'b1, 1'b0, 32'h14, 32'd0, 2, 1'b0, 1'b1, 32'h600DCAFE, "lat1_lw_0x14", 1'b0, d1);
        tests++;
        if (d1 - d0 !== 3) begin
            fails++;
            $display("FAIL lat1_back_to_back done_spacing: got %0d want 3", d1 - d0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_conflict();
        test_input_churn();
        test_reset_mid_access();
        test_lat1_wrap_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
